alu_cmd_sequencer: RTL and testbench

- Automated driver for the ALU board's pushbutton/switch command interface, and the initiator counterpart of the board's pb/sw receiver.
- Accepts one ALU command over a valid/ready handshake.
- Replays it as the timed switch/button sequence the board expects: clear, load A, load B, capture output.
- Samples the LED result and returns it over a second valid/ready handshake.
- Sits between a host/self-test source and the board's pb/sw/led pins, for hardware-in-loop regression without manual button presses.

---
 rtl/alu_seq_pkg.sv | 51 +++++
 rtl/alu_cmd_sequencer_if.sv | 27 ++
 rtl/alu_cmd_sequencer_phase_timer.sv | 30 +++
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
//   state_t : sequencer FSM states
//   step_t  : strobe step currently being replayed (value doubles as pb bit index)
//   PB_*    : pb_out bit positions of the board buttons
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        STEP_CLR = 2'd0,
        STEP_LDA = 2'd1,
        STEP_LDB = 2'd2,
        STEP_OUT = 2'd3
    } step_t;

    localparam int PB_RST = 0;
    localparam int PB_LDA = 1;
    localparam int PB_LDB = 2;
    localparam int PB_OUT = 3;

    function automatic logic [3:0] pb_mask(input step_t step);
        logic [3:0] m;
        m = '0;
        case (step)
            STEP_CLR: m[PB_RST] = 1'b1;
            STEP_LDA: m[PB_LDA] = 1'b1;
            STEP_LDB: m[PB_LDB] = 1'b1;
            default:  m[PB_OUT] = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] step_sw(input step_t step, input logic [3:0] a,
                                           input logic [3:0] b, input logic [2:0] sel,
                                           input logic hi);
        case (step)
            STEP_CLR: return 4'h0;
            STEP_LDA: return a;
            STEP_LDB: return b;
            default:  return {hi, sel};
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle of the ALU command sequencer.
//   master : host / self-test source (offers commands, consumes responses)
//   slave  : the sequencer
interface alu_cmd_sequencer_if #(parameter int WIDTH = 4);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       cmd_sel;
    logic             cmd_hi;
    logic             cmd_clr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_led;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_hi, cmd_clr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_led
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_hi, cmd_clr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_led
    );

endinterface

// File: rtl/alu_cmd_sequencer_phase_timer.sv
// phase_timer: loadable down-counter timing the sequencer phases.
//   clk, rst (async, active-low)
//   load     : load load_val this edge
//   load_val : cycles-minus-one of the phase being entered
//   done     : counter has reached 0 (phase ends at the next edge)
module phase_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: replays one ALU command as the timed pb/sw sequence the
// board expects (optional clear, load A, load B, capture) and returns the LED
// result.
//   clk, rst (async, active-low)
//   bus    : command/response handshakes (slave side)
//   pb_out : button drive, at most one bit high
//   sw_out : switch drive, changes only when a setup phase is entered
//   led_in : board LED result, sampled once per command
//   busy   : high whenever not idle
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a command, cmd_ready high
// ST_SETUP  | sw_out carries the step value, buttons released
// ST_STROBE | step button pressed, sw_out held
// ST_WAIT   | settle time after the capture strobe
// ST_SAMPLE | led_in captured into rsp_led
// ST_RESP   | rsp_valid high until the host takes it
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int HOLD   = 4,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus,
    output logic [3:0]          pb_out,
    output logic [3:0]          sw_out,
    input  logic [3:0]          led_in,
    output logic                busy
);

    localparam int MAXP = (HOLD > SETTLE) ? HOLD : SETTLE;
    localparam int CW   = $clog2(MAXP) + 1;
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

    state_t           state;
    step_t            step;
    step_t            next_step;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       sel_q;
    logic             hi_q;
    logic             clr_q;
    logic             rsp_valid_q;
    logic [3:0]       rsp_led_q;
    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_done;

    // Reset is folded in so the host sees not-ready while the board is held.
    assign bus.cmd_ready = rst & (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_led   = rsp_led_q;
    assign next_step     = step_t'(step + 2'd1);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        case (state)
            ST_IDLE:   tmr_load = bus.cmd_valid;
            ST_SETUP:  tmr_load = tmr_done;
            ST_STROBE: begin
                tmr_load = tmr_done;
                if (step == STEP_OUT) tmr_val = SETTLE_LD;
            end
            default: ;
        endcase
    end

    phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            step        <= STEP_CLR;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            hi_q        <= 1'b0;
            clr_q       <= 1'b0;
            pb_out      <= '0;
            sw_out      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_led_q   <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        a_q   <= bus.cmd_a;
                        b_q   <= bus.cmd_b;
                        sel_q <= bus.cmd_sel;
                        hi_q  <= bus.cmd_hi;
                        clr_q <= bus.cmd_clr;
                        if (bus.cmd_clr) begin
                            step   <= STEP_CLR;
                            sw_out <= 4'h0;
                        end else begin
                            step   <= STEP_LDA;
                            sw_out <= 4'(bus.cmd_a);
                        end
                        busy  <= 1'b1;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        pb_out <= pb_mask(step);
                        state  <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (tmr_done) begin
                        pb_out <= '0;
                        if (step == STEP_OUT) begin
                            state <= ST_WAIT;
                        end else begin
                            step   <= next_step;
                            sw_out <= step_sw(next_step, 4'(a_q), 4'(b_q), sel_q, hi_q);
                            state  <= ST_SETUP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (tmr_done) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    rsp_led_q   <= led_in;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // clr_q is latched with the command for completeness; the step order
    // already encodes whether the clear strobe was issued.
    logic unused_clr;
    assign unused_clr = clr_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    localparam int WIDTH  = 4;
    localparam int HOLD   = 2;
    localparam int SETTLE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pb_out;
    logic [3:0] sw_out;
    logic [3:0] led_in;
    logic       busy;

    alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus();

    alu_cmd_sequencer #(.WIDTH(WIDTH), .HOLD(HOLD), .SETTLE(SETTLE)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pb_out (pb_out),
        .sw_out (sw_out),
        .led_in (led_in),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Expected pb/sw value for every cycle between acceptance and rsp_valid.
    logic [3:0] exp_pb[$];
    logic [3:0] exp_sw[$];

    task automatic check(input string tag, input int cyc, input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    // Behavioural model: each step is HOLD cycles of switches alone, then HOLD
    // cycles with its button; then SETTLE wait cycles plus one sample cycle.
    task automatic build_trace(input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] sel, input logic hi, input logic clr);
        logic [3:0] vals[4];
        logic [3:0] masks[4];
        vals[0] = 4'h0;      masks[0] = 4'b0001;
        vals[1] = a;         masks[1] = 4'b0010;
        vals[2] = b;         masks[2] = 4'b0100;
        vals[3] = {hi, sel}; masks[3] = 4'b1000;
        exp_pb.delete();
        exp_sw.delete();
        for (int s = (clr ? 0 : 1); s < 4; s++) begin
            for (int i = 0; i < HOLD; i++) begin exp_pb.push_back(4'h0);     exp_sw.push_back(vals[s]); end
            for (int i = 0; i < HOLD; i++) begin exp_pb.push_back(masks[s]); exp_sw.push_back(vals[s]); end
        end
        for (int i = 0; i < SETTLE + 1; i++) begin
            exp_pb.push_back(4'h0);
            exp_sw.push_back({hi, sel});
        end
    endtask

    task automatic scramble_cmd();
        bus.cmd_a   = 4'($urandom);
        bus.cmd_b   = 4'($urandom);
        bus.cmd_sel = 3'($urandom);
        bus.cmd_hi  = 1'($urandom);
        bus.cmd_clr = 1'($urandom);
    endtask

    // Called at a negedge with the sequencer idle; returns at a negedge idle.
    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                           input logic hi, input logic clr, input logic [3:0] led,
                           input int stall, input bit early, input bit poke);
        logic [3:0] out_v;
        int         n_stall;
        out_v   = {hi, sel};
        n_stall = early ? 0 : stall;
        build_trace(a, b, sel, hi, clr);
        check("ready_before_cmd", 0, {busy, bus.cmd_ready}, 2'b01);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = sel;
        bus.cmd_hi    = hi;
        bus.cmd_clr   = clr;
        bus.rsp_ready = early;
        led_in        = ~led;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = poke;
        scramble_cmd();
        for (int k = 0; k < exp_pb.size(); k++) begin
            led_in = (k == exp_pb.size() - 1) ? led : ~led;
            check("pb_trace", k, pb_out, exp_pb[k]);
            check("sw_trace", k, sw_out, exp_sw[k]);
            check("busy_rspv_ready", k, {busy, bus.rsp_valid, bus.cmd_ready}, 3'b100);
            if (poke) scramble_cmd();
            @(negedge clk);
        end
        for (int s = 0; s <= n_stall; s++) begin
            led_in = 4'($urandom);
            check("rsp_valid", s, bus.rsp_valid, 1'b1);
            check("rsp_led", s, bus.rsp_led, led);
            check("rsp_busy_ready_pb", s, {busy, bus.cmd_ready, pb_out}, {2'b10, 4'h0});
            check("rsp_sw_hold", s, sw_out, out_v);
            if (poke) scramble_cmd();
            if (s < n_stall) @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid_ready_busy", 0, {bus.rsp_valid, bus.cmd_ready, busy}, 3'b010);
        check("post_rsp_pb", 0, pb_out, 4'h0);
        check("post_rsp_sw", 0, sw_out, out_v);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_sel   = '0;
        bus.cmd_hi    = 1'b0;
        bus.cmd_clr   = 1'b0;
        bus.rsp_ready = 1'b0;
        led_in        = 4'h0;

        repeat (2) @(negedge clk);
        check("rst_pb_sw", 0, {pb_out, sw_out}, 8'h00);
        check("rst_rsp_led", 0, bus.rsp_led, 4'h0);
        check("rst_valid_busy_ready", 0, {bus.rsp_valid, busy, bus.cmd_ready}, 3'b000);
        rst = 1'b1;
        #1;
        check("ready_after_rst", 0, bus.cmd_ready, 1'b1);
        @(negedge clk);

        run_cmd(4'h3, 4'h5, 3'd2, 1'b0, 1'b1, 4'h8, 0, 1'b0, 1'b0);
        run_cmd(4'h3, 4'h5, 3'd2, 1'b0, 1'b0, 4'h8, 0, 1'b0, 1'b0);
        run_cmd(4'h3, 4'h5, 3'd7, 1'b1, 1'b1, 4'h1, 0, 1'b0, 1'b1);
        run_cmd(4'hA, 4'h6, 3'd4, 1'b0, 1'b1, 4'hC, 10, 1'b0, 1'b1);
        run_cmd(4'h9, 4'h2, 3'd1, 1'b1, 1'b0, 4'h5, 0, 1'b1, 1'b0);

        // Abort during the LDB strobe.
        build_trace(4'h7, 4'hE, 3'd3, 1'b1, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 4'h7;
        bus.cmd_b     = 4'hE;
        bus.cmd_sel   = 3'd3;
        bus.cmd_hi    = 1'b1;
        bus.cmd_clr   = 1'b1;
        led_in        = 4'h6;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 4 * HOLD + HOLD; k++) @(negedge clk);
        check("abort_pre_pb", 0, pb_out, exp_pb[4 * HOLD + HOLD]);
        check("abort_pre_sw", 0, sw_out, 4'hE);
        rst = 1'b0;
        #1;
        check("abort_pb_sw", 0, {pb_out, sw_out}, 8'h00);
        check("abort_busy_valid_ready", 0, {busy, bus.rsp_valid, bus.cmd_ready}, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready_after_release", 0, bus.cmd_ready, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("abort_no_rsp", k, {bus.rsp_valid, busy, pb_out}, {2'b00, 4'h0});
        end

        for (int i = 0; i < 20; i++) begin
            run_cmd(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
